// File: rtl/md5_pkg.sv
// rtl/md5_pkg.sv - shared constants and state type for the MD5 guess generator
package md5_pkg;

    localparam logic [7:0] CHAR_MIN = 8'h61;
    localparam logic [7:0] CHAR_MAX = 8'h7A;
    localparam int         GUESS_W  = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PRESENT,
        ST_FOUND,
        ST_EXHAUSTED
    } state_e;

endpackage

// File: rtl/md5_char_digit.sv
// rtl/md5_char_digit.sv - one odometer character digit with wrap and carry
module md5_char_digit #(
    parameter logic [7:0] CHAR_MAX = md5_pkg::CHAR_MAX
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic [7:0] i_step,
    input  logic [7:0] i_wrap_val,
    input  logic       i_carry_in,
    output logic [7:0] o_char,
    output logic       o_carry_out
);

    logic [7:0] r_char;
    logic [8:0] w_sum;
    logic       w_ovf;

    assign w_sum       = {1'b0, r_char} + {1'b0, i_step};
    assign w_ovf       = (w_sum > {1'b0, CHAR_MAX});
    assign o_carry_out = i_carry_in && w_ovf;
    assign o_char      = r_char;

    // load outranks stepping so the top can reload or freeze the whole odometer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_char <= 8'h00;
        end else if (i_load) begin
            r_char <= i_load_val;
        end else if (i_carry_in) begin
            r_char <= w_ovf ? i_wrap_val : w_sum[7:0];
        end
    end

endmodule

// File: rtl/md5_guess_generator.sv
// rtl/md5_guess_generator.sv - length-growing lowercase password enumerator for one cracker core
module md5_guess_generator #(
    parameter int         MAX_LEN  = 8,
    parameter logic [7:0] CHAR_MIN = md5_pkg::CHAR_MIN,
    parameter logic [7:0] CHAR_MAX = md5_pkg::CHAR_MAX,
    parameter int         COUNT_W  = 32
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_start,
    input  logic [2:0]                  i_increment,
    input  logic [7:0]                  i_starting_position,
    input  logic                        i_found,
    input  logic                        i_guess_ready,
    output logic                        o_guess_valid,
    output logic [md5_pkg::GUESS_W-1:0] o_guess,
    output logic [4:0]                  o_guess_len,
    output logic                        o_done,
    output logic                        o_exhausted,
    output logic [COUNT_W-1:0]          o_guess_count
);
    import md5_pkg::*;

    state_e               r_state;
    state_e               w_next;
    logic [2:0]           r_inc;
    logic [7:0]           r_start;
    logic [4:0]           r_len;
    logic [COUNT_W-1:0]   r_count;
    logic [7:0]           w_char     [MAX_LEN];
    logic [7:0]           w_load_val [MAX_LEN];
    logic [MAX_LEN-1:0]   w_carry;
    logic                 w_hs;
    logic                 w_adv;
    logic                 w_carry_last;
    logic                 w_grow;
    logic                 w_load;
    logic                 w_start_ok;

    assign w_start_ok = (r_state == ST_IDLE) || (r_state == ST_FOUND) || (r_state == ST_EXHAUSTED);
    assign w_hs       = (r_state == ST_PRESENT) && i_guess_ready;
    assign w_adv      = w_hs && !i_found;
    assign w_grow     = w_adv && w_carry_last && (r_len < 5'(MAX_LEN));
    // on final carry the digits reload: fresh length on growth, own value when exhausted
    assign w_load     = (r_state == ST_LOAD) || (w_adv && w_carry_last);

    always_comb begin
        w_carry_last = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (5'(i) == r_len - 5'd1) w_carry_last = w_carry[i];
        end
    end

    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            if (r_state == ST_LOAD) begin
                w_load_val[i] = (i == 0) ? r_start : 8'h00;
            end else if (w_grow) begin
                w_load_val[i] = (i == 0) ? r_start : ((5'(i) <= r_len) ? CHAR_MIN : 8'h00);
            end else begin
                w_load_val[i] = w_char[i];
            end
        end
    end

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_digit
        if (g == 0) begin : g_lead
            md5_char_digit #(.CHAR_MAX(CHAR_MAX)) u_digit (
                .i_clk       (i_clk),
                .i_rst_n     (i_rst_n),
                .i_load      (w_load),
                .i_load_val  (w_load_val[g]),
                .i_step      ({5'd0, r_inc}),
                .i_wrap_val  (r_start),
                .i_carry_in  (w_adv),
                .o_char      (w_char[g]),
                .o_carry_out (w_carry[g])
            );
        end else begin : g_tail
            md5_char_digit #(.CHAR_MAX(CHAR_MAX)) u_digit (
                .i_clk       (i_clk),
                .i_rst_n     (i_rst_n),
                .i_load      (w_load),
                .i_load_val  (w_load_val[g]),
                .i_step      (8'd1),
                .i_wrap_val  (CHAR_MIN),
                .i_carry_in  (w_carry[g-1]),
                .o_char      (w_char[g]),
                .o_carry_out (w_carry[g])
            );
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_FOUND, ST_EXHAUSTED: if (i_start) w_next = ST_LOAD;
            ST_LOAD:    w_next = i_found ? ST_FOUND : ST_PRESENT;
            ST_PRESENT: begin
                if (i_found)                                w_next = ST_FOUND;
                else if (w_adv && w_carry_last && !w_grow) w_next = ST_EXHAUSTED;
            end
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_inc   <= 3'd1;
            r_start <= CHAR_MIN;
            r_len   <= 5'd0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (i_start && w_start_ok) begin
                r_inc   <= (i_increment == 3'd0) ? 3'd1 : i_increment;
                r_start <= ((i_starting_position < CHAR_MIN) || (i_starting_position > CHAR_MAX))
                           ? CHAR_MIN : i_starting_position;
            end
            if (r_state == ST_LOAD) begin
                r_len   <= 5'd1;
                r_count <= '0;
            end else begin
                if (w_grow) r_len <= r_len + 5'd1;
                if (w_hs && (r_count != '1)) r_count <= r_count + 1'b1;
            end
        end
    end

    always_comb begin
        o_guess = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            o_guess[GUESS_W-1-8*i -: 8] = w_char[i];
        end
    end

    assign o_guess_valid = (r_state == ST_PRESENT);
    assign o_guess_len   = r_len;
    assign o_done        = (r_state == ST_FOUND) || (r_state == ST_EXHAUSTED);
    assign o_exhausted   = (r_state == ST_EXHAUSTED);
    assign o_guess_count = r_count;

endmodule

// File: tb/tb_md5_guess_generator.sv
// tb/tb_md5_guess_generator.sv - randomized self-checking bench for md5_guess_generator
module tb_md5_guess_generator;

    localparam int MAX_LEN = 2;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_start = 1'b0;
    logic [2:0]   i_increment = 3'd0;
    logic [7:0]   i_starting_position = 8'h00;
    logic         i_found = 1'b0;
    logic         i_guess_ready = 1'b0;
    logic         o_guess_valid;
    logic [127:0] o_guess;
    logic [4:0]   o_guess_len;
    logic         o_done;
    logic         o_exhausted;
    logic [31:0]  o_guess_count;

    int n_checks = 0;
    int n_pass   = 0;

    md5_guess_generator #(.MAX_LEN(MAX_LEN)) dut (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .i_start             (i_start),
        .i_increment         (i_increment),
        .i_starting_position (i_starting_position),
        .i_found             (i_found),
        .i_guess_ready       (i_guess_ready),
        .o_guess_valid       (o_guess_valid),
        .o_guess             (o_guess),
        .o_guess_len         (o_guess_len),
        .o_done              (o_done),
        .o_exhausted         (o_exhausted),
        .o_guess_count       (o_guess_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic int eff_s(input logic [7:0] sp);
        return ((sp < 8'h61) || (sp > 8'h7A)) ? 32'h61 : int'(sp);
    endfunction

    function automatic int eff_d(input logic [2:0] inc);
        return (inc == 3'd0) ? 1 : int'(inc);
    endfunction

    function automatic int total_of(input int s, input int d);
        int n0 = (32'h7A - s) / d + 1;
        int blk = n0;
        int tot = 0;
        for (int l = 1; l <= MAX_LEN; l++) begin
            tot += blk;
            blk *= 26;
        end
        return tot;
    endfunction

    // k-th candidate: all length-1 guesses, then length-2, ... ; char0 varies fastest
    task automatic model(input int s, input int d, input int k, output logic [127:0] g, output int len);
        int n0 = (32'h7A - s) / d + 1;
        int blk = n0;
        int q;
        len = 1;
        while (k >= blk && len < MAX_LEN) begin
            k -= blk;
            blk *= 26;
            len++;
        end
        g = '0;
        g[127:120] = 8'(s + d * (k % n0));
        q = k / n0;
        for (int i = 1; i < len; i++) begin
            g[127-8*i -: 8] = 8'(32'h61 + q % 26);
            q /= 26;
        end
    endtask

    task automatic run_case(input logic [7:0] sp, input logic [2:0] inc, input int found_at, input int stall_pct);
        int s = eff_s(sp);
        int d = eff_d(inc);
        int total = total_of(s, d);
        int idx = 0;
        int cyc = 0;
        int mlen;
        logic ready;
        logic [127:0] mg;
        @(negedge i_clk);
        i_start = 1'b1;
        i_increment = inc;
        i_starting_position = sp;
        @(negedge i_clk);
        i_start = 1'b0;
        while (!o_done && cyc < 5000) begin
            ready = ($urandom_range(99, 0) >= stall_pct);
            i_guess_ready = ready;
            i_found = 1'b0;
            if (o_guess_valid) begin
                model(s, d, idx, mg, mlen);
                chk("guess", o_guess, mg);
                chk("guess_len", 128'(o_guess_len), 128'(mlen));
                if (ready) begin
                    chk("count_before_hs", 128'(o_guess_count), 128'(idx));
                    if (idx == found_at) i_found = 1'b1;
                    idx++;
                end
            end
            @(negedge i_clk);
            cyc++;
        end
        i_found = 1'b0;
        i_guess_ready = 1'b0;
        chk("timeout", 128'(cyc < 5000), 128'(1));
        chk("done", 128'(o_done), 128'(1));
        chk("valid_after_done", 128'(o_guess_valid), 128'(0));
        if (found_at >= 0) begin
            model(s, d, found_at, mg, mlen);
            chk("found_exhausted", 128'(o_exhausted), 128'(0));
            chk("found_count", 128'(o_guess_count), 128'(found_at + 1));
            chk("found_guess", o_guess, mg);
        end else begin
            model(s, d, total - 1, mg, mlen);
            chk("exhausted", 128'(o_exhausted), 128'(1));
            chk("exh_count", 128'(o_guess_count), 128'(total));
            chk("exh_guess", o_guess, mg);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, 128'(o_guess_valid), 128'(0));
        chk({tag, "_guess"}, o_guess, 128'(0));
        chk({tag, "_len"},   128'(o_guess_len), 128'(0));
        chk({tag, "_done"},  128'(o_done), 128'(0));
        chk({tag, "_exh"},   128'(o_exhausted), 128'(0));
        chk({tag, "_count"}, 128'(o_guess_count), 128'(0));
    endtask

    task automatic reset_mid_run();
        int cyc = 0;
        @(negedge i_clk);
        i_start = 1'b1;
        i_increment = 3'd1;
        i_starting_position = 8'h61;
        @(negedge i_clk);
        i_start = 1'b0;
        i_guess_ready = 1'b1;
        while (!(o_guess_len == 5'd2 && o_guess_count >= 32'd30) && cyc < 200) begin
            @(negedge i_clk);
            cyc++;
        end
        chk("mid_len2", 128'(o_guess_len), 128'(2));
        i_rst_n = 1'b0;
        #1;
        check_reset_values("rst_mid");
        @(negedge i_clk);
        i_guess_ready = 1'b0;
        i_rst_n = 1'b1;
    endtask

    initial begin
        int sp;
        int inc;
        int fa;
        repeat (2) @(negedge i_clk);
        check_reset_values("rst");
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check_reset_values("idle");

        run_case(8'h61, 3'd1, -1, 0);
        run_case(8'h62, 3'd2, -1, 30);
        run_case(8'h61, 3'd1, 4, 0);
        run_case(8'h7B, 3'd0, -1, 20);
        reset_mid_run();
        run_case(8'h61, 3'd1, 2, 40);

        for (int r = 0; r < 5; r++) begin
            sp  = $urandom_range(8'h7F, 8'h58);
            inc = $urandom_range(7, 0);
            fa  = -1;
            if ($urandom_range(1, 0) == 1)
                fa = $urandom_range(total_of(eff_s(8'(sp)), eff_d(3'(inc))) - 1, 0);
            run_case(8'(sp), 3'(inc), fa, 25);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
